// File: rtl/mux_arbiter.sv
// mux_arbiter: 7:1 crossbar output arbiter.
// Priority select, round-robin ties, starvation aging.
module mux_arbiter #(
    parameter int NumPorts      = 7,
    parameter int PriorityWidth = 8,
    parameter int AgeWidth      = 4,
    parameter int StarveLimit   = 15
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NumPorts-1:0]               req,
    input  logic [NumPorts*PriorityWidth-1:0] prio,
    input  logic [NumPorts-1:0]               port_en,
    input  logic                              out_stall,
    output logic [NumPorts-1:0]               consume,
    output logic [2:0]                        sel_index,
    output logic                              sel_valid_q,
    output logic [2:0]                        sel_index_q
);

    localparam logic [AgeWidth-1:0] Lim = AgeWidth'(StarveLimit);
    localparam logic [2:0]          LastIdx = 3'(NumPorts - 1);

    logic [2:0]               rr_ptr;
    logic [AgeWidth-1:0]      age [NumPorts];

    logic [NumPorts-1:0]      eligible;
    logic [NumPorts-1:0]      starving;
    logic [NumPorts-1:0]      top_prio;
    logic [NumPorts-1:0]      cand;
    logic [PriorityWidth-1:0] max_prio;
    logic [2:0]               win;
    logic                     found;
    logic                     active;

    assign eligible = req & port_en;
    assign active   = rst & ~out_stall & (|eligible);

    // Flag eligible ports whose age counter has saturated.
    always_comb begin
        starving = '0;
        for (int i = 0; i < NumPorts; i++) begin
            starving[i] = eligible[i] && (age[i] == Lim);
        end
    end

    // Highest priority among eligible ports.
    always_comb begin
        max_prio = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (eligible[i] &&
                prio[i*PriorityWidth +: PriorityWidth] > max_prio) begin
                max_prio = prio[i*PriorityWidth +: PriorityWidth];
            end
        end
    end

    // Candidates: starving ports override the priority set.
    always_comb begin
        top_prio = '0;
        for (int i = 0; i < NumPorts; i++) begin
            top_prio[i] = eligible[i] &&
                (prio[i*PriorityWidth +: PriorityWidth] == max_prio);
        end
        cand = (|starving) ? starving : top_prio;
    end

    // Round-robin scan of candidates starting at rr_ptr.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NumPorts; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NumPorts) begin
                j = j - NumPorts;
            end
            if (!found && cand[j]) begin
                found = 1'b1;
                win   = 3'(j);
            end
        end
    end

    // Grant outputs are gated to zero on idle, stall and reset.
    always_comb begin
        consume   = '0;
        sel_index = '0;
        if (active) begin
            consume   = {{(NumPorts-1){1'b0}}, 1'b1} << win;
            sel_index = win;
        end
    end

    // Pointer, ages and registered select advance only when not stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr      <= '0;
            sel_valid_q <= 1'b0;
            sel_index_q <= '0;
            for (int i = 0; i < NumPorts; i++) begin
                age[i] <= '0;
            end
        end else if (!out_stall) begin
            sel_valid_q <= active;
            sel_index_q <= sel_index;
            if (active) begin
                rr_ptr <= (win == LastIdx) ? 3'd0 : win + 3'd1;
                for (int i = 0; i < NumPorts; i++) begin
                    if (3'(i) == win) begin
                        age[i] <= '0;
                    end else if (eligible[i] && age[i] != Lim) begin
                        age[i] <= age[i] + AgeWidth'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: scoreboard bench for mux_arbiter.
// Expected grants queued by stimulus, popped by monitor.
module tb_mux_arbiter;

    logic        clk;
    logic        rst;
    logic [6:0]  req;
    logic [55:0] prio;
    logic [6:0]  port_en;
    logic        out_stall;
    logic [6:0]  consume;
    logic [2:0]  sel_index;
    logic        sel_valid_q;
    logic [2:0]  sel_index_q;

    int checks = 0;
    int errors = 0;
    int gq[$];
    int rq[$];
    logic stall_prev = 1'b0;

    mux_arbiter dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .prio(prio),
        .port_en(port_en),
        .out_stall(out_stall),
        .consume(consume),
        .sel_index(sel_index),
        .sel_valid_q(sel_valid_q),
        .sel_index_q(sel_index_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic g(input int idx);
        gq.push_back(idx);
        rq.push_back(idx);
    endtask

    task automatic set_prio(input int base, input int p3);
        for (int i = 0; i < 7; i++) begin
            prio[i*8 +: 8] = 8'(base);
        end
        prio[31:24] = 8'(p3);
    endtask

    // Monitor: combinational grant and registered select vs queues.
    always @(negedge clk) begin
        int e;
        if (consume != 7'd0) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: consume=%b", consume);
            end else begin
                e = gq.pop_front();
                chk("grant_index", int'(sel_index), e);
                chk("grant_onehot", int'(consume), 1 << e);
            end
        end
        if (!stall_prev && sel_valid_q === 1'b1) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_q: idx=%0d", sel_index_q);
            end else begin
                e = rq.pop_front();
                chk("index_q", int'(sel_index_q), e);
            end
        end
        stall_prev = out_stall;
    end

    initial begin
        int seq[7];
        rst       = 1'b0;
        req       = 7'h7F;
        port_en   = 7'h7F;
        out_stall = 1'b0;
        set_prio(5, 5);

        // Reset held two cycles with every port requesting
        tick();
        tick();
        chk("rst_consume", int'(consume), 0);
        chk("rst_sel_index", int'(sel_index), 0);
        chk("rst_valid_q", int'(sel_valid_q), 0);
        chk("rst_index_q", int'(sel_index_q), 0);

        // Round-robin over equal priorities
        rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            g(i);
            tick();
            chk("rr_valid_q", int'(sel_valid_q), 1);
        end
        g(0);
        tick();

        // Reset mid-grant
        rst = 1'b0;
        #1;
        chk("midrst_consume", int'(consume), 0);
        chk("midrst_sel_index", int'(sel_index), 0);
        tick();
        chk("midrst_valid_q", int'(sel_valid_q), 0);
        chk("midrst_index_q", int'(sel_index_q), 0);
        rst = 1'b1;

        // Priority then starvation aging
        set_prio(5, 9);
        for (int i = 0; i < 15; i++) begin
            g(3);
            tick();
        end
        seq = '{4, 5, 6, 0, 1, 2, 3};
        for (int i = 0; i < 7; i++) begin
            g(seq[i]);
            tick();
        end

        // Stall mid-stream
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req = 7'h05;
        set_prio(5, 5);
        g(0);
        tick();
        g(2);
        tick();
        out_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_consume", int'(consume), 0);
            chk("stall_index_q", int'(sel_index_q), 2);
            chk("stall_valid_q", int'(sel_valid_q), 1);
            tick();
        end
        out_stall = 1'b0;
        g(0);
        tick();
        g(2);
        tick();

        // Disabled port and empty FIFOs
        port_en = 7'h7E;
        req     = 7'h01;
        #1;
        chk("dis_consume", int'(consume), 0);
        tick();
        chk("dis_valid_q", int'(sel_valid_q), 0);
        req = 7'h41;
        g(6);
        tick();
        chk("en_valid_q", int'(sel_valid_q), 1);

        // Pointer wrap 6 -> 0
        port_en = 7'h7F;
        req     = 7'h20;
        g(5);
        tick();
        req = 7'h41;
        g(6);
        tick();
        g(0);
        tick();
        req = 7'h00;

        // Drain with bounded wait
        for (int i = 0; i < 10; i++) begin
            if (gq.size() == 0 && rq.size() == 0) break;
            tick();
        end
        chk("grant_queue_left", gq.size(), 0);
        chk("index_q_queue_left", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Arbitration controller for the 7-input crossbar output mux: one 7:1 arbiter per switch output. It selects which input FIFO (local, yneg, ypos, xpos, xneg, zpos, zneg) is read each cycle. Selection is by packet priority field, with round-robin tie-breaking and starvation aging. It drives the FIFO consume strobes and the select index. It also produces a registered valid/index pair aligned with the mux's first-stage data register, and honours a downstream stall.

## Interface
- NumPorts, 7: number of requesters. Index 0 = local, 1..6 = yneg, ypos, xpos, xneg, zpos, zneg.
- PriorityWidth, 8: width of each port's priority field.
- AgeWidth, 4: width of each starvation counter.
- StarveLimit, 15: counter value at which a port is starving. Must be ≤ 2^AgeWidth−1.

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- req  in  NumPorts  FIFO non-empty per port (~FIFO_empty)
- prio  in  NumPorts*PriorityWidth  priority of each FIFO head; port i at [i*PriorityWidth +: PriorityWidth]
- port_en  in  NumPorts  per-port enable; a disabled port is never granted
- out_stall  in  1  downstream pipeline stall
- consume  out  NumPorts  one-hot FIFO read strobe, combinational
- sel_index  out  3  combinational winner index, drives FIFO output select
- sel_valid_q  out  1  registered: data latched this cycle is valid
- sel_index_q  out  3  registered index of latched data

## Operation
- Eligible(i) = req[i] & port_en[i].
- Active cycle: out_stall=0 and at least one port eligible.
- Starving(i) = eligible(i) & (age[i] == StarveLimit).
- Winner selection (combinational, evaluated every cycle):
  1. If any port is starving, the candidate set is the starving ports. Otherwise it is the eligible ports with maximal prio (unsigned compare).
  2. Among candidates, choose the first found scanning rr_ptr, rr_ptr+1, …, wrapping 6→0.
- consume = onehot(winner) when the cycle is active, else all 0. sel_index = winner when active, else 0.
- On each active cycle:
  - rr_ptr <= (winner+1) mod 7, so 6 wraps to 0.
  - age[winner] <= 0.
  - Every other eligible port i: age[i] <= min(age[i]+1, StarveLimit), saturating.
  - Non-eligible ports keep their age.
- Non-active cycle with out_stall=0 (nothing eligible): rr_ptr and ages unchanged.
- out_stall=1:
  - consume = 0.
  - rr_ptr, ages, sel_valid_q and sel_index_q hold their values.
- Registered outputs, when out_stall=0:
  - sel_valid_q <= active.
  - sel_index_q <= sel_index.
- port_en deasserted mid-operation: that port's age is frozen, not cleared. When re-enabled it resumes from its frozen value.
- prio is sampled only combinationally. Ports that are not eligible do not participate, regardless of their prio value.

## Timing
- consume and sel_index are valid in the same cycle as req/prio (zero latency). The FIFO pops at the end of that cycle.
- sel_valid_q and sel_index_q appear 1 cycle later, aligned with the mux data register.
- Back-to-back grants: one per cycle with no bubbles while eligible ports exist and out_stall=0.
- Stall edges:
  - out_stall rising in cycle N: no pop in cycle N; registered outputs keep their cycle N−1 values.
  - out_stall falling: arbitration resumes that same cycle.
- Reset, applied at any time including mid-stall or mid-grant: on the first clock edge with rst=0, rr_ptr=0, all age=0, sel_valid_q=0, sel_index_q=0. While rst=0, consume=0 and sel_index=0.
- Worst-case wait for an always-eligible, enabled port: StarveLimit cycles to reach starving, plus at most 6 further cycles for round-robin among starving ports.

## Test plan
- Reset: drive garbage state, hold rst=0 for 2 cycles with req=7'h7F -> consume=0, sel_valid_q=0, sel_index_q=0. The first active cycle after release grants port 0.
- Round-robin: req=7'h7F, all prio=5, no stall -> sel_index sequence 0,1,2,3,4,5,6,0. sel_index_q follows one cycle later. sel_valid_q=1 continuously.
- Priority and aging: req=7'h7F, prio[3]=9, others 5 ->
  - Port 3 wins cycles 0–14.
  - At cycle 15 all other ports are starving; port 4 is granted (rr_ptr=4), then 5, 6, 0, 1, 2.
  - Port 3 then wins again.
- Stall: stream with req=7'h05 equal prio, out_stall=1 for 3 cycles mid-stream -> consume=0 during the stall. sel_index_q/sel_valid_q hold. The grant order resumes 0,2,0,2 with no skipped or duplicated grant.
- Enable and empty: port_en=7'h7E, req=7'h01 -> consume=0 and sel_valid_q=0 next cycle. Setting req=7'h41 then grants only port 6.
- Wrap: rr_ptr=6 after granting port 5, req=7'h41 equal prio -> port 6 granted, then port 0 (rr_ptr wraps to 0).
